// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: per-warp two-slot buffers and scoreboards; picks one ready warp per cycle for single/dual issue.
// Optional WARP_PRIORITY_EN: highest launch_prio wins, ties round-robin; otherwise pure round-robin.
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WB    = 2,
  parameter int PC_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                launch_valid,
  input  logic [3:0]          launch_warp,
  input  logic [PC_W-1:0]     launch_pc,
  input  logic [3:0]          launch_prio,
  input  logic                fetch_valid,
  input  logic [3:0]          fetch_warp,
  input  logic [63:0]         fetch_bundle,
  output logic                fetch_ready,
  input  logic [NUM_WB-1:0]   wb_valid,
  input  logic [4*NUM_WB-1:0] wb_warp,
  input  logic [5*NUM_WB-1:0] wb_reg,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [3:0]          issue_warp,
  output logic [PC_W-1:0]     issue_pc,
  output logic [31:0]         issue_pri,
  output logic [31:0]         issue_sec,
  output logic                issue_dual,
  output logic [7:0]          active_warps,
  output logic                busy,
  output logic [31:0]         issue_count,
  output logic [15:0]         dual_count
);
  localparam int WW = $clog2(NUM_WARPS);
  logic [NUM_WARPS-1:0] valid_q, valid_d, s0v_q, s0v_d, s1v_q, s1v_d, rdy, dual_ok;
  logic [PC_W-1:0]      pc_q [NUM_WARPS];
  logic [PC_W-1:0]      pc_d [NUM_WARPS];
  logic [31:0]          s0_q [NUM_WARPS];
  logic [31:0]          s0_d [NUM_WARPS];
  logic [31:0]          s1_q [NUM_WARPS];
  logic [31:0]          s1_d [NUM_WARPS];
  logic [NUM_REGS-1:0]  sb_q [NUM_WARPS];
  logic [NUM_REGS-1:0]  sb_d [NUM_WARPS];
  logic [WW-1:0]        last_q, last_d, sel, idx, fw, lw;
  logic                 found, go, acc, iv_q, iv_d, idual_q, idual_d;
  logic [3:0]           iwarp_q, iwarp_d;
  logic [PC_W-1:0]      ipc_q, ipc_d;
  logic [31:0]          ipri_q, ipri_d, isec_q, isec_d, ic_q, ic_d;
  logic [15:0]          dc_q, dc_d;
`ifdef WARP_PRIORITY_EN
  logic [3:0]           prio_q [NUM_WARPS];
  logic [3:0]           prio_d [NUM_WARPS];
  logic [3:0]           best;
`else
  logic                 unused_prio;
  assign unused_prio = ^launch_prio;
`endif

  function automatic logic cx(input logic [31:0] x);
    return x[31:27] == 5'h04 || x[31:27] == 5'h05;
  endfunction

  assign fw = fetch_warp[WW-1:0];
  assign lw = launch_warp[WW-1:0];
  assign fetch_ready = {1'b0, fetch_warp} < 5'(NUM_WARPS) && valid_q[fw] && !s0v_q[fw] && !s1v_q[fw];
  assign acc = iv_q && issue_ready;
  assign go = found && (!iv_q || issue_ready);
  assign issue_valid = iv_q;
  assign issue_warp = iwarp_q;
  assign issue_pc = ipc_q;
  assign issue_pri = ipri_q;
  assign issue_sec = isec_q;
  assign issue_dual = idual_q;
  assign issue_count = ic_q;
  assign dual_count = dc_q;
  assign busy = |valid_q || iv_q;

  always_comb begin
    rdy = '0;
    dual_ok = '0;
    active_warps = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      active_warps = active_warps + 8'(valid_q[i]);
      rdy[i] = valid_q[i] && s0v_q[i] && !sb_q[i][s0_q[i][21:17]] && !sb_q[i][s0_q[i][16:12]]
               && !sb_q[i][s0_q[i][26:22]];
      // op < 0x18 admits ALU/TEX/LOAD in slot1 and rejects EXIT
      dual_ok[i] = s1v_q[i] && !sb_q[i][s1_q[i][21:17]] && !sb_q[i][s1_q[i][16:12]]
                   && !sb_q[i][s1_q[i][26:22]] && s0_q[i][31:27] < 5'h10 && s1_q[i][31:27] < 5'h18
                   && !(s1_q[i][31:27] < 5'h10 && (cx(s0_q[i]) || cx(s1_q[i])))
                   && !(s0_q[i][26:22] != 5'd0 && (s0_q[i][26:22] == s1_q[i][21:17]
                        || s0_q[i][26:22] == s1_q[i][16:12] || s0_q[i][26:22] == s1_q[i][26:22]));
    end
  end

  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
`ifdef WARP_PRIORITY_EN
    best = '0;
`endif
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = WW'((int'(last_q) + 1 + k) % NUM_WARPS);
`ifdef WARP_PRIORITY_EN
      if (rdy[idx] && (!found || prio_q[idx] > best)) begin
        found = 1'b1;
        sel = idx;
        best = prio_q[idx];
      end
`else
      if (rdy[idx] && !found) begin
        found = 1'b1;
        sel = idx;
      end
`endif
    end
  end

  always_comb begin
    valid_d = valid_q;
    s0v_d = s0v_q;
    s1v_d = s1v_q;
    pc_d = pc_q;
    s0_d = s0_q;
    s1_d = s1_q;
    sb_d = sb_q;
`ifdef WARP_PRIORITY_EN
    prio_d = prio_q;
`endif
    last_d = last_q;
    iv_d = iv_q && !issue_ready;
    iwarp_d = iwarp_q;
    ipc_d = ipc_q;
    ipri_d = ipri_q;
    isec_d = isec_q;
    idual_d = idual_q;
    ic_d = ic_q + (acc ? (idual_q ? 32'd2 : 32'd1) : 32'd0);
    dc_d = dc_q + {15'd0, acc && idual_q};
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && {1'b0, wb_warp[4*p +: 4]} < 5'(NUM_WARPS))
        sb_d[wb_warp[4*p +: WW]][wb_reg[5*p +: 5]] = 1'b0;
    if (launch_valid && {1'b0, launch_warp} < 5'(NUM_WARPS) && !valid_q[lw]) begin
      valid_d[lw] = 1'b1;
      pc_d[lw] = launch_pc;
      s0v_d[lw] = 1'b0;
      s1v_d[lw] = 1'b0;
      sb_d[lw] = '0;
`ifdef WARP_PRIORITY_EN
      prio_d[lw] = launch_prio;
`endif
    end
    if (fetch_valid && fetch_ready) begin
      s0_d[fw] = fetch_bundle[31:0];
      s1_d[fw] = fetch_bundle[63:32];
      s0v_d[fw] = 1'b1;
      s1v_d[fw] = |fetch_bundle[63:32];
    end
    if (go) begin
      iv_d = 1'b1;
      iwarp_d = 4'(sel);
      ipc_d = pc_q[sel];
      ipri_d = s0_q[sel];
      isec_d = dual_ok[sel] ? s1_q[sel] : 32'd0;
      idual_d = dual_ok[sel];
      last_d = sel;
      if (s0_q[sel][31:27] == 5'h1F) begin
        valid_d[sel] = 1'b0;
        s0v_d[sel] = 1'b0;
        s1v_d[sel] = 1'b0;
      end else begin
        // set after the writeback clears so a same-edge wb cannot erase a fresh pending bit
        if (s0_q[sel][26:22] != 5'd0) sb_d[sel][s0_q[sel][26:22]] = 1'b1;
        if (dual_ok[sel]) begin
          if (s1_q[sel][26:22] != 5'd0) sb_d[sel][s1_q[sel][26:22]] = 1'b1;
          s0v_d[sel] = 1'b0;
          s1v_d[sel] = 1'b0;
          pc_d[sel] = pc_q[sel] + PC_W'(2);
        end else begin
          s0_d[sel] = s1_q[sel];
          s0v_d[sel] = s1v_q[sel];
          s1v_d[sel] = 1'b0;
          pc_d[sel] = pc_q[sel] + PC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      s0v_q <= '0;
      s1v_q <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        pc_q[i] <= '0;
        s0_q[i] <= '0;
        s1_q[i] <= '0;
        sb_q[i] <= '0;
`ifdef WARP_PRIORITY_EN
        prio_q[i] <= '0;
`endif
      end
      last_q <= WW'(NUM_WARPS - 1);
      iv_q <= 1'b0;
      iwarp_q <= '0;
      ipc_q <= '0;
      ipri_q <= '0;
      isec_q <= '0;
      idual_q <= 1'b0;
      ic_q <= '0;
      dc_q <= '0;
    end else begin
      valid_q <= valid_d;
      s0v_q <= s0v_d;
      s1v_q <= s1v_d;
      pc_q <= pc_d;
      s0_q <= s0_d;
      s1_q <= s1_d;
      sb_q <= sb_d;
`ifdef WARP_PRIORITY_EN
      prio_q <= prio_d;
`endif
      last_q <= last_d;
      iv_q <= iv_d;
      iwarp_q <= iwarp_d;
      ipc_q <= ipc_d;
      ipri_q <= ipri_d;
      isec_q <= isec_d;
      idual_q <= idual_d;
      ic_q <= ic_d;
      dc_q <= dc_d;
    end
  end
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb_warp_issue_scheduler: directed scenarios for warp_issue_scheduler with hand-computed expectations.
module tb_warp_issue_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        launch_valid = 1'b0, fetch_valid = 1'b0, issue_ready = 1'b1;
  logic [3:0]  launch_warp = '0, launch_prio = '0, fetch_warp = '0;
  logic [15:0] launch_pc = '0;
  logic [63:0] fetch_bundle = '0;
  logic [1:0]  wb_valid = '0;
  logic [7:0]  wb_warp = '0;
  logic [9:0]  wb_reg = '0;
  logic        fetch_ready, issue_valid, issue_dual, busy;
  logic [3:0]  issue_warp;
  logic [15:0] issue_pc, dual_count;
  logic [31:0] issue_pri, issue_sec, issue_count;
  logic [7:0]  active_warps;
  int n_cmp = 0, n_fail = 0;

  warp_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n), .launch_valid(launch_valid), .launch_warp(launch_warp),
    .launch_pc(launch_pc), .launch_prio(launch_prio), .fetch_valid(fetch_valid),
    .fetch_warp(fetch_warp), .fetch_bundle(fetch_bundle), .fetch_ready(fetch_ready),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_reg(wb_reg), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_warp(issue_warp), .issue_pc(issue_pc),
    .issue_pri(issue_pri), .issue_sec(issue_sec), .issue_dual(issue_dual),
    .active_warps(active_warps), .busy(busy), .issue_count(issue_count), .dual_count(dual_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    return {op, d, a, b, 12'h000};
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] w, input logic [15:0] pc, input logic [3:0] pr);
    launch_valid = 1'b1; launch_warp = w; launch_pc = pc; launch_prio = pr;
    tick;
    launch_valid = 1'b0;
  endtask

  task automatic fetch(input logic [3:0] w, input logic [31:0] sec, input logic [31:0] pri);
    fetch_valid = 1'b1; fetch_warp = w; fetch_bundle = {sec, pri};
    tick;
    fetch_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [1:0] v, input logic [3:0] w0, input logic [4:0] r0, input logic [3:0] w1, input logic [4:0] r1);
    wb_valid = v; wb_warp = {w1, w0}; wb_reg = {r1, r0};
    tick;
    wb_valid = '0;
  endtask

  task automatic test_reset;
    tick; tick;
    n_cmp++;
    if ({issue_valid, busy, fetch_ready, active_warps, issue_count, dual_count} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b busy=%b fr=%b act=%0d ic=%0d dc=%0d want all 0",
               issue_valid, busy, fetch_ready, active_warps, issue_count, dual_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    launch(4'd0, 16'h10, 4'd0);
    fetch_warp = 4'd0; #1;
    n_cmp++;
    if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL single_fetch_ready: got %b want 1", fetch_ready); end
    fetch(4'd0, 32'd0, ins(5'h00, 5'd3, 5'd1, 5'd2));
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: got valid %b want 0", issue_valid); end
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_warp, issue_pc, issue_pri, issue_sec} !== {1'b1, 1'b0, 4'd0, 16'h10, ins(5'h00, 5'd3, 5'd1, 5'd2), 32'd0}) begin
      n_fail++;
      $display("FAIL single_issue: got v=%b d=%b w=%0d pc=%h pri=%h sec=%h want v=1 d=0 w=0 pc=0010 pri=%h sec=0",
               issue_valid, issue_dual, issue_warp, issue_pc, issue_pri, issue_sec, ins(5'h00, 5'd3, 5'd1, 5'd2));
    end
    tick;
    n_cmp++;
    if ({issue_valid, issue_count, busy, active_warps} !== {1'b0, 32'd1, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL single_count: got v=%b ic=%0d busy=%b act=%0d want v=0 ic=1 busy=1 act=1", issue_valid, issue_count, busy, active_warps);
    end
  endtask

  task automatic test_dual;
    do_wb(2'b01, 4'd0, 5'd3, 4'd0, 5'd0);
    fetch(4'd0, ins(5'h10, 5'd5, 5'd6, 5'd0), ins(5'h00, 5'd3, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc, issue_sec} !== {1'b1, 1'b1, 16'h11, ins(5'h10, 5'd5, 5'd6, 5'd0)}) begin
      n_fail++;
      $display("FAIL dual_issue: got v=%b d=%b pc=%h sec=%h want v=1 d=1 pc=0011 sec=%h",
               issue_valid, issue_dual, issue_pc, issue_sec, ins(5'h10, 5'd5, 5'd6, 5'd0));
    end
    tick;
    n_cmp++;
    if ({issue_count, dual_count} !== {32'd3, 16'd1}) begin
      n_fail++; $display("FAIL dual_counts: got ic=%0d dc=%0d want ic=3 dc=1", issue_count, dual_count);
    end
    fetch(4'd0, 32'd0, ins(5'h00, 5'd7, 5'd3, 5'd1));
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d: got valid %b want 0", i, issue_valid); end
      tick;
    end
    do_wb(2'b10, 4'd0, 5'd0, 4'd0, 5'd3);
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wb_no_bypass: got valid %b want 0", issue_valid); end
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc} !== {1'b1, 1'b0, 16'h13}) begin
      n_fail++; $display("FAIL after_wb_issue: got v=%b d=%b pc=%h want v=1 d=0 pc=0013", issue_valid, issue_dual, issue_pc);
    end
    tick;
    do_wb(2'b11, 4'd0, 5'd5, 4'd0, 5'd7);
  endtask

  task automatic test_split;
    fetch(4'd0, ins(5'h04, 5'd8, 5'd1, 5'd2), ins(5'h00, 5'd4, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc} !== {1'b1, 1'b0, 16'h14}) begin
      n_fail++; $display("FAIL complex_split_a: got v=%b d=%b pc=%h want v=1 d=0 pc=0014", issue_valid, issue_dual, issue_pc);
    end
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc, issue_pri} !== {1'b1, 1'b0, 16'h15, ins(5'h04, 5'd8, 5'd1, 5'd2)}) begin
      n_fail++; $display("FAIL complex_split_b: got v=%b d=%b pc=%h pri=%h want v=1 d=0 pc=0015", issue_valid, issue_dual, issue_pc, issue_pri);
    end
    tick;
    n_cmp++;
    if (issue_count !== 32'd6) begin n_fail++; $display("FAIL complex_count: got %0d want 6", issue_count); end
    do_wb(2'b11, 4'd0, 5'd4, 4'd0, 5'd8);
    fetch(4'd0, ins(5'h01, 5'd9, 5'd4, 5'd1), ins(5'h00, 5'd4, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc} !== {1'b1, 1'b0, 16'h16}) begin
      n_fail++; $display("FAIL raw_split_a: got v=%b d=%b pc=%h want v=1 d=0 pc=0016", issue_valid, issue_dual, issue_pc);
    end
    tick;
    n_cmp++;
    if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL raw_split_stall: got valid %b want 0", issue_valid); end
    do_wb(2'b01, 4'd0, 5'd4, 4'd0, 5'd0);
    tick;
    n_cmp++;
    if ({issue_valid, issue_dual, issue_pc} !== {1'b1, 1'b0, 16'h17}) begin
      n_fail++; $display("FAIL raw_split_b: got v=%b d=%b pc=%h want v=1 d=0 pc=0017", issue_valid, issue_dual, issue_pc);
    end
    tick;
    n_cmp++;
    if ({issue_count, dual_count} !== {32'd8, 16'd1}) begin
      n_fail++; $display("FAIL split_counts: got ic=%0d dc=%0d want ic=8 dc=1", issue_count, dual_count);
    end
    do_wb(2'b01, 4'd0, 5'd9, 4'd0, 5'd0);
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_w [4];
`ifdef WARP_PRIORITY_EN
    exp_w[0] = 4'd2; exp_w[1] = 4'd2; exp_w[2] = 4'd0; exp_w[3] = 4'd1;
`else
    exp_w[0] = 4'd0; exp_w[1] = 4'd1; exp_w[2] = 4'd2; exp_w[3] = 4'd0;
`endif
    launch(4'd1, 16'h100, 4'd0);
    launch(4'd2, 16'h200, 4'hF);
    launch(4'd3, 16'h300, 4'd0);
    issue_ready = 1'b0;
    fetch(4'd3, 32'd0, ins(5'h00, 5'd3, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_warp, active_warps} !== {1'b1, 4'd3, 8'd4}) begin
      n_fail++; $display("FAIL rr_setup: got v=%b w=%0d act=%0d want v=1 w=3 act=4", issue_valid, issue_warp, active_warps);
    end
    for (int w = 0; w < 3; w++) fetch(4'(w), ins(5'h04, 5'd11, 5'd1, 5'd2), ins(5'h00, 5'd10, 5'd1, 5'd2));
    n_cmp++;
    if (issue_warp !== 4'd3) begin n_fail++; $display("FAIL rr_hold: got w=%0d want 3", issue_warp); end
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++;
      if ({issue_valid, issue_warp} !== {1'b1, exp_w[k]}) begin
        n_fail++; $display("FAIL rr_order_%0d: got v=%b w=%0d want v=1 w=%0d", k, issue_valid, issue_warp, exp_w[k]);
      end
    end
    tick; tick; tick;
    n_cmp++;
    if ({issue_valid, issue_count} !== {1'b0, 32'd15}) begin
      n_fail++; $display("FAIL rr_drain: got v=%b ic=%0d want v=0 ic=15", issue_valid, issue_count);
    end
  endtask

  task automatic test_hold_exit;
    issue_ready = 1'b0;
    fetch(4'd2, 32'd0, ins(5'h00, 5'd12, 5'd1, 5'd2));
    tick;
    fetch(4'd1, 32'd0, ins(5'h1F, 5'd0, 5'd0, 5'd0));
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({issue_valid, issue_warp, issue_pc, issue_pri, issue_count} !== {1'b1, 4'd2, 16'h202, ins(5'h00, 5'd12, 5'd1, 5'd2), 32'd15}) begin
        n_fail++; $display("FAIL hold_%0d: got v=%b w=%0d pc=%h pri=%h ic=%0d want v=1 w=2 pc=0202 ic=15",
                           i, issue_valid, issue_warp, issue_pc, issue_pri, issue_count);
      end
      tick;
    end
    issue_ready = 1'b1;
    tick;
    fetch_warp = 4'd1; #1;
    n_cmp++;
    if ({issue_warp, issue_pri, active_warps, fetch_ready} !== {4'd1, 32'hF800_0000, 8'd3, 1'b0}) begin
      n_fail++; $display("FAIL exit: got w=%0d pri=%h act=%0d fr=%b want w=1 pri=f8000000 act=3 fr=0",
                         issue_warp, issue_pri, active_warps, fetch_ready);
    end
    tick;
    n_cmp++;
    if ({issue_valid, issue_count} !== {1'b0, 32'd17}) begin
      n_fail++; $display("FAIL exit_count: got v=%b ic=%0d want v=0 ic=17", issue_valid, issue_count);
    end
  endtask

  task automatic test_launch_edges;
    launch(4'd0, 16'h55, 4'd0);
    launch(4'd9, 16'h99, 4'd0);
    n_cmp++;
    if (active_warps !== 8'd3) begin n_fail++; $display("FAIL launch_ignored: got act=%0d want 3", active_warps); end
    fetch(4'd0, 32'd0, ins(5'h00, 5'd13, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 4'd0, 16'h1A}) begin
      n_fail++; $display("FAIL relaunch_valid_pc: got v=%b w=%0d pc=%h want v=1 w=0 pc=001a", issue_valid, issue_warp, issue_pc);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    issue_ready = 1'b0;
    fetch(4'd3, 32'd0, ins(5'h00, 5'd13, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_warp, issue_count} !== {1'b1, 4'd3, 32'd18}) begin
      n_fail++; $display("FAIL pre_reset: got v=%b w=%0d ic=%0d want v=1 w=3 ic=18", issue_valid, issue_warp, issue_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({issue_valid, busy, active_warps, issue_count, dual_count} !== 58'd0) begin
      n_fail++; $display("FAIL async_reset: got v=%b busy=%b act=%0d ic=%0d dc=%0d want all 0",
                         issue_valid, busy, active_warps, issue_count, dual_count);
    end
    tick;
    rst_n = 1'b1;
    issue_ready = 1'b1;
    launch(4'd3, 16'h40, 4'd0);
    n_cmp++;
    if (active_warps !== 8'd1) begin n_fail++; $display("FAIL relaunch_active: got %0d want 1", active_warps); end
    fetch(4'd3, 32'd0, ins(5'h00, 5'd3, 5'd1, 5'd2));
    tick;
    n_cmp++;
    if ({issue_valid, issue_warp, issue_pc} !== {1'b1, 4'd3, 16'h40}) begin
      n_fail++; $display("FAIL relaunch_issue: got v=%b w=%0d pc=%h want v=1 w=3 pc=0040", issue_valid, issue_warp, issue_pc);
    end
    tick;
    n_cmp++;
    if (issue_count !== 32'd1) begin n_fail++; $display("FAIL relaunch_count: got %0d want 1", issue_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_dual;
    test_split;
    test_round_robin;
    test_hold_exit;
    test_launch_edges;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Parametrised successor to the dual-issue execution front end.
- Holds a two-slot instruction buffer and a per-register scoreboard for each warp, then picks one ready warp per cycle.
- Issues a single instruction or a dual-issue pair through a registered valid/ready port to the ALU/TEX/LOAD pipes.
- Execution pipes return writebacks on NUM_WB ports; these clear scoreboard bits.

Parameters:
- NUM_WARPS, 8: warp contexts (2..16).
- NUM_REGS, 32: architectural registers per warp (5-bit index field).
- NUM_WB, 2: writeback ports.
- PC_W, 16: program counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- launch_valid  in  1  start a warp
- launch_warp  in  4  warp id
- launch_pc  in  PC_W  start PC
- launch_prio  in  4  warp priority (larger = higher)
- fetch_valid  in  1  bundle available
- fetch_warp  in  4  target warp
- fetch_bundle  in  64  [31:0] primary, [63:32] secondary
- fetch_ready  out  1  both buffer slots of fetch_warp empty and warp valid (combinational)
- wb_valid  in  NUM_WB  per-port writeback strobe
- wb_warp  in  4*NUM_WB  writeback warp ids
- wb_reg  in  5*NUM_WB  writeback register indices
- issue_valid  out  1  issue register full
- issue_ready  in  1  downstream accepts
- issue_warp  out  4  issued warp id
- issue_pc  out  PC_W  PC of primary instruction
- issue_pri  out  32  primary instruction
- issue_sec  out  32  secondary instruction, 0 when not dual
- issue_dual  out  1  pair issued
- active_warps  out  8  count of valid warps
- busy  out  1  any warp valid or issue_valid
- issue_count  out  32  instructions accepted
- dual_count  out  16  pairs accepted

Behaviour:
- Reset: all warps invalid, buffers empty, scoreboards clear. All outputs 0, including issue_valid, counters, active_warps, busy, fetch_ready.
- Instruction fields: op[31:27], dst[26:22], src1[21:17], src2[16:12].
- Op classes:
  - ALU: op<0x10; complex ALU: op 0x04/0x05.
  - TEX: 0x10-0x13; LOAD: 0x14-0x17.
  - EXIT: 0x1F. EXIT writes no register.
- Register 0: never marked pending.
- Launch:
  - If launch_warp is invalid: set valid, PC=launch_pc, prio, empty buffer, clear scoreboard.
  - If launch_warp is already valid: launch ignored.
  - Launch to a warp id >= NUM_WARPS: ignored.
- Fetch: on fetch_valid && fetch_ready, load both slots; slot1 empty if the secondary is a NOP (all zero).
- Warp ready conditions:
  - valid, and slot0 full;
  - slot0 src1/src2/dst not pending;
  - issue register free (empty, or accepted this cycle).
- Dual issue: requires all of the following.
  - Slot1 full, not EXIT, and its sources/dst not pending.
  - Slot0 is ALU and slot1 is TEX, LOAD, or ALU. For ALU+ALU, neither may be complex.
  - No RAW: slot0.dst != slot1.src1/src2. No WAW: slot0.dst != slot1.dst (both nonzero).
- Single issue after one slot issues: slot1 shifts into slot0 and slot1 becomes empty. PC advances by 1 for single issue, 2 for dual.
- Selection:
  - Round-robin starting at the warp after the last issued one.
  - One warp is loaded into the issue register per cycle.
  - Issued dst bits are set in the scoreboard on the same edge.
- Scoreboard timing:
  - Scoreboard is checked against registered state; no writeback bypass, so a wb clears the bit and issue can occur the next cycle.
  - Simultaneous wb on two ports to the same register: harmless.
  - wb to a non-pending register: no effect.
- EXIT: once loaded into the issue register, the warp becomes invalid and its buffer is cleared. A pending scoreboard is kept until the next launch.
- Handshake:
  - While issue_valid && !issue_ready, all issue outputs hold stable and no new selection occurs.
  - Latency: fetch accepted at edge N → earliest issue_valid high after edge N+1.
- Counters:
  - On issue handshake, issue_count += 1 or 2; dual_count += 1 if issue_dual.
  - Both counters wrap.
- active_warps: combinational popcount.
- Reset mid-operation: everything returns to reset state asynchronously.

Optional Feature:
WARP_PRIORITY_EN:
- Defined: selection picks the highest launch_prio among ready warps; ties are broken round-robin.
- Undefined: launch_prio is ignored and selection is pure round-robin.

Test Plan:
- Launch warp 0 pc 0x10, fetch {sec=0, pri=ADD op0 r3=r1+r2} → issue_valid 2nd cycle after fetch, issue_pc=0x10, issue_dual=0, issue_count=1.
- Fetch {TEX r5←r6, ADD r3←r1,r2} → issue_dual=1, issue_sec=TEX word; next bundle ADD r7←r3,r1 stalls until wb_valid r3, then issues 1 cycle after wb; dual_count=1.
- Pair ADD r4, DIV op0x04 → issued as two single issues, PC +1 each; pair ADD r4 then ALU reading r4 → split into two single issues.
- Warps 0,1,2 launched, all ready, issue_ready=1 → issue order 0,1,2,0; with WARP_PRIORITY_EN and warp 2 prio 0xF → warp 2 always first.
- Hold issue_ready=0 for 5 cycles → issue outputs constant, no scoreboard change; EXIT on warp 1 → active_warps 3→2, fetch_ready for warp 1 = 0.
- Assert rst_n=0 mid-issue → issue_valid, counters, active_warps 0 immediately; relaunch of the same warp accepted.
